// File: rtl/calc_pkg.sv
// Shared types for the calculator scheduler: FSM state encoding and the
// function codes understood by the downstream calculator.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [1:0] ADD = 2'd0;
  localparam logic [1:0] SUB = 2'd1;
  localparam logic [1:0] MUL = 2'd2;
  localparam logic [1:0] DIV = 2'd3;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that was not served last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_served ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/calc_scheduler.sv
// Shares one multi-cycle calculator between two requesters: arbitrates,
// issues the operation, waits for completion or timeout, and returns a response.
module calc_scheduler
  import calc_pkg::*;
#(
  parameter int width          = 8,
  parameter int timeout_cycles = 64
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [1:0]           req_i,
  input  logic [width-1:0]     a0_i,
  input  logic [width-1:0]     b0_i,
  input  logic [width-1:0]     a1_i,
  input  logic [width-1:0]     b1_i,
  input  logic [1:0]           fct0_i,
  input  logic [1:0]           fct1_i,
  output logic [1:0]           gnt_o,
  output logic                 calc_start_o,
  output logic [width-1:0]     calc_a_o,
  output logic [width-1:0]     calc_b_o,
  output logic [1:0]           calc_fct_o,
  input  logic [2*width-1:0]   calc_res_i,
  input  logic [2*width-1:0]   calc_rem_i,
  input  logic                 calc_done_i,
  output logic [2*width-1:0]   res_o,
  output logic [2*width-1:0]   rem_o,
  output logic [1:0]           valid_o,
  output logic                 err_o,
  output logic                 busy_o
);

  // The counter holds WAIT cycles already spent; the last legal one triggers the abort.
  localparam logic [7:0] TIMEOUT_LAST = 8'(timeout_cycles - 1);

  state_t     state;
  state_t     state_next;
  logic [1:0] arb_grant;
  logic       winner;
  logic       last_served;
  logic [7:0] wait_count;

  logic load_op;
  logic count_clear;
  logic count_inc;
  logic take_done;
  logic take_timeout;
  logic update_last;

  rr_arbiter2 u_arb (
    .req         (req_i),
    .last_served (last_served),
    .grant       (arb_grant)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    gnt_o        = 2'b00;
    calc_start_o = 1'b0;
    valid_o      = 2'b00;
    busy_o       = 1'b1;
    load_op      = 1'b0;
    count_clear  = 1'b0;
    count_inc    = 1'b0;
    take_done    = 1'b0;
    take_timeout = 1'b0;
    update_last  = 1'b0;
    unique case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (req_i != 2'b00) begin
          gnt_o      = arb_grant;
          load_op    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        calc_start_o = 1'b1;
        count_clear  = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
        if (calc_done_i) begin
          take_done  = 1'b1;
          state_next = RESP;
        end else if (wait_count == TIMEOUT_LAST) begin
          take_timeout = 1'b1;
          state_next   = RESP;
        end else begin
          count_inc = 1'b1;
        end
      end
      RESP: begin
        valid_o     = onehot2(winner);
        update_last = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Pulses are suppressed while reset is asserted so an aborted cycle never looks like a handshake.
    if (reset_i) begin
      gnt_o        = 2'b00;
      calc_start_o = 1'b0;
      valid_o      = 2'b00;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      calc_a_o    <= '0;
      calc_b_o    <= '0;
      calc_fct_o  <= 2'b00;
      winner      <= 1'b0;
      last_served <= 1'b1;
      wait_count  <= 8'd0;
      res_o       <= '0;
      rem_o       <= '0;
      err_o       <= 1'b0;
    end else begin
      if (load_op) begin
        winner     <= arb_grant[1];
        calc_a_o   <= arb_grant[1] ? a1_i   : a0_i;
        calc_b_o   <= arb_grant[1] ? b1_i   : b0_i;
        calc_fct_o <= arb_grant[1] ? fct1_i : fct0_i;
      end
      if (count_clear) begin
        wait_count <= 8'd0;
      end else if (count_inc) begin
        wait_count <= wait_count + 8'd1;
      end
      if (take_done) begin
        res_o <= calc_res_i;
        rem_o <= calc_rem_i;
        err_o <= 1'b0;
      end else if (take_timeout) begin
        res_o <= '0;
        rem_o <= '0;
        err_o <= 1'b1;
      end
      if (update_last) begin
        last_served <= winner;
      end
    end
  end

endmodule

// File: tb/tb_calc_scheduler.sv
// Directed bench for calc_scheduler: a transaction-timeline model is checked
// against the DUT every cycle, plus literal expectations for each scenario.
module tb_calc_scheduler;
  import calc_pkg::*;

  localparam int W  = 8;
  localparam int TO = 64;

  logic           clock_i = 1'b0;
  logic           reset_i = 1'b1;
  logic [1:0]     req_i = 2'b00;
  logic [W-1:0]   a0_i = '0, b0_i = '0, a1_i = '0, b1_i = '0;
  logic [1:0]     fct0_i = 2'b00, fct1_i = 2'b00;
  logic [1:0]     gnt_o;
  logic           calc_start_o;
  logic [W-1:0]   calc_a_o, calc_b_o;
  logic [1:0]     calc_fct_o;
  logic [2*W-1:0] calc_res_i, calc_rem_i;
  logic           calc_done_i;
  logic [2*W-1:0] res_o, rem_o;
  logic [1:0]     valid_o;
  logic           err_o, busy_o;

  calc_scheduler #(.width(W), .timeout_cycles(TO)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .req_i(req_i),
    .a0_i(a0_i), .b0_i(b0_i), .a1_i(a1_i), .b1_i(b1_i),
    .fct0_i(fct0_i), .fct1_i(fct1_i), .gnt_o(gnt_o),
    .calc_start_o(calc_start_o), .calc_a_o(calc_a_o), .calc_b_o(calc_b_o),
    .calc_fct_o(calc_fct_o), .calc_res_i(calc_res_i), .calc_rem_i(calc_rem_i),
    .calc_done_i(calc_done_i), .res_o(res_o), .rem_o(rem_o),
    .valid_o(valid_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Calculator stub: done for one cycle on the chosen WAIT cycle after start.
  bit             stub_en = 1'b0;
  int             stub_delay = 1;
  logic [2*W-1:0] stub_res = '0, stub_rem = '0;
  bit             stub_done = 1'b0;
  bit             manual_done = 1'b0;
  int             start_cyc = -1000;

  assign calc_done_i = stub_done | manual_done;
  assign calc_res_i  = stub_res;
  assign calc_rem_i  = stub_rem;

  initial forever begin
    @(posedge clock_i);
    #1;
    stub_done = stub_en && (cyc - start_cyc == stub_delay);
  end

  // Event log
  int         gnt_cnt = 0, start_cnt = 0, valid_cnt = 0;
  int         gnt_cyc = 0, valid_cyc = 0;
  logic [1:0] last_gnt = 2'b00, last_valid = 2'b00;
  logic [1:0] gnt_log[$];
  logic [1:0] valid_log[$];
  int         gnt_cyc_log[$];

  // Reference model: one transaction at a time, located on a timeline by its grant cycle.
  bit             m_on = 1'b0;
  bit             m_busy = 1'b0;
  int             m_gcyc = 0;
  bit             m_win = 1'b0;
  bit             m_last = 1'b1;
  int             m_resp = -1;
  logic [W-1:0]   m_a = '0, m_b = '0;
  logic [1:0]     m_fct = 2'b00;
  logic [2*W-1:0] m_res = '0, m_rem = '0;
  bit             m_err = 1'b0;
  int             m_off;
  logic [1:0]     e_gnt, e_valid;
  bit             e_start;

  function automatic logic [1:0] rr_pick(input logic [1:0] req, input bit last);
    if (req == 2'b11) return last ? 2'b01 : 2'b10;
    return req;
  endfunction

  always @(negedge clock_i) begin
    if (m_on) begin
      m_off   = cyc - m_gcyc;
      e_gnt   = (!m_busy && !reset_i) ? rr_pick(req_i, m_last) : 2'b00;
      e_start = m_busy && (m_off == 1) && !reset_i;
      e_valid = (m_busy && cyc == m_resp && !reset_i) ? (m_win ? 2'b10 : 2'b01) : 2'b00;

      check_output("busy", busy_o, m_busy);
      check_output("gnt", gnt_o, e_gnt);
      check_output("start", calc_start_o, e_start);
      check_output("valid", valid_o, e_valid);
      check_output("calc_a", calc_a_o, m_a);
      check_output("calc_b", calc_b_o, m_b);
      check_output("calc_fct", calc_fct_o, m_fct);
      check_output("res", res_o, m_res);
      check_output("rem", rem_o, m_rem);
      check_output("err", err_o, m_err);

      if (gnt_o != 2'b00) begin
        gnt_cnt++; gnt_cyc = cyc; last_gnt = gnt_o;
        gnt_log.push_back(gnt_o); gnt_cyc_log.push_back(cyc);
      end
      if (calc_start_o) begin start_cnt++; start_cyc = cyc; end
      if (valid_o != 2'b00) begin
        valid_cnt++; valid_cyc = cyc; last_valid = valid_o;
        valid_log.push_back(valid_o);
      end

      if (reset_i) begin
        m_busy = 1'b0; m_last = 1'b1; m_resp = -1;
        m_a = '0; m_b = '0; m_fct = 2'b00;
        m_res = '0; m_rem = '0; m_err = 1'b0;
      end else if (!m_busy) begin
        if (req_i != 2'b00) begin
          m_busy = 1'b1; m_gcyc = cyc; m_win = e_gnt[1]; m_resp = -1;
          m_a   = m_win ? a1_i : a0_i;
          m_b   = m_win ? b1_i : b0_i;
          m_fct = m_win ? fct1_i : fct0_i;
        end
      end else if (cyc == m_resp) begin
        m_last = m_win; m_busy = 1'b0;
      end else if (m_off >= 2 && m_resp < 0) begin
        if (calc_done_i) begin
          m_res = calc_res_i; m_rem = calc_rem_i; m_err = 1'b0; m_resp = cyc + 1;
        end else if (m_off - 1 == TO) begin
          m_res = '0; m_rem = '0; m_err = 1'b1; m_resp = cyc + 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock_i);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] req, input bit who, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [1:0] fct);
    if (who) begin a1_i = a; b1_i = b; fct1_i = fct; end
    else     begin a0_i = a; b0_i = b; fct0_i = fct; end
    req_i = req;
  endtask

  task automatic set_stub(input bit en, input int delay, input logic [2*W-1:0] res, input logic [2*W-1:0] rem);
    stub_en = en; stub_delay = delay; stub_res = res; stub_rem = rem;
  endtask

  task automatic wait_grant(input int max_cycles, input string name);
    int base = gnt_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick(1);
      if (gnt_cnt > base) seen = 1'b1;
    end
    check_output(name, seen, 1);
  endtask

  task automatic wait_valid(input int max_cycles, input string name);
    int base = valid_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick(1);
      if (valid_cnt > base) seen = 1'b1;
    end
    check_output(name, seen, 1);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick(2);
    reset_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] exp_pat[4];
    int         base_start, base_valid;
    exp_pat = '{2'b01, 2'b10, 2'b01, 2'b10};

    tick(2);
    m_on = 1'b1;
    check_output("reset_busy", busy_o, 0);
    check_output("reset_gnt", gnt_o, 0);
    check_output("reset_valid", valid_o, 0);
    check_output("reset_res", res_o, 0);
    check_output("reset_calc_a", calc_a_o, 0);
    reset_i = 1'b0;
    tick(1);

    // Single requester 0, ADD, done on the first WAIT cycle
    set_stub(1'b1, 1, 16'd17, 16'd0);
    base_start = start_cnt;
    apply_stimulus(2'b01, 1'b0, 8'd12, 8'd5, ADD);
    wait_grant(5, "t1_grant_seen");
    req_i = 2'b00;
    wait_valid(10, "t1_valid_seen");
    check_output("t1_gnt", last_gnt, 2'b01);
    check_output("t1_start_cycle", start_cyc - gnt_cyc, 1);
    check_output("t1_start_count", start_cnt - base_start, 1);
    check_output("t1_valid_cycle", valid_cyc - gnt_cyc, 3);
    check_output("t1_valid", last_valid, 2'b01);
    check_output("t1_res", res_o, 17);
    check_output("t1_err", err_o, 0);

    // Both requesters continuously after reset
    do_reset();
    gnt_log.delete(); valid_log.delete(); gnt_cyc_log.delete();
    apply_stimulus(2'b11, 1'b0, 8'd1, 8'd2, SUB);
    apply_stimulus(2'b11, 1'b1, 8'd3, 8'd4, MUL);
    for (int i = 0; i < 4; i++) wait_valid(10, "t2_valid_seen");
    req_i = 2'b00;
    check_output("t2_grant_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) check_output("t2_grant_order", gnt_log[i], exp_pat[i]);
    for (int i = 0; i < 4 && i < valid_log.size(); i++) check_output("t2_valid_order", valid_log[i], exp_pat[i]);
    if (gnt_cyc_log.size() >= 2) check_output("t2_grant_spacing", gnt_cyc_log[1] - gnt_cyc_log[0], 4);
    tick(2);

    // Requester 1 DIV, operands changed after grant
    set_stub(1'b1, 5, 16'd28, 16'd4);
    apply_stimulus(2'b10, 1'b1, 8'd200, 8'd7, DIV);
    wait_grant(5, "t3_grant_seen");
    apply_stimulus(2'b00, 1'b1, 8'd99, 8'd1, ADD);
    wait_valid(20, "t3_valid_seen");
    check_output("t3_calc_a", calc_a_o, 200);
    check_output("t3_calc_b", calc_b_o, 7);
    check_output("t3_calc_fct", calc_fct_o, DIV);
    check_output("t3_valid", last_valid, 2'b10);
    check_output("t3_res", res_o, 28);
    check_output("t3_rem", rem_o, 4);
    check_output("t3_latency", valid_cyc - start_cyc, 6);

    // Calculator never completes: timeout
    set_stub(1'b0, 1, 16'd55, 16'd66);
    apply_stimulus(2'b01, 1'b0, 8'd9, 8'd3, MUL);
    wait_grant(5, "t4_grant_seen");
    req_i = 2'b00;
    wait_valid(100, "t4_valid_seen");
    check_output("t4_timeout_cycle", valid_cyc - start_cyc, 65);
    check_output("t4_err", err_o, 1);
    check_output("t4_res", res_o, 0);
    check_output("t4_rem", rem_o, 0);
    check_output("t4_valid", last_valid, 2'b01);

    // Reset in WAIT; late done must be ignored
    set_stub(1'b1, 5, 16'd77, 16'd1);
    apply_stimulus(2'b01, 1'b0, 8'd5, 8'd6, ADD);
    wait_grant(5, "t5_grant_seen");
    req_i = 2'b00;
    tick(2);
    base_valid = valid_cnt;
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    tick(6);
    check_output("t5_no_valid", valid_cnt - base_valid, 0);
    check_output("t5_busy", busy_o, 0);
    check_output("t5_res", res_o, 0);
    check_output("t5_err", err_o, 0);
    check_output("t5_calc_a", calc_a_o, 0);
    apply_stimulus(2'b11, 1'b1, 8'd8, 8'd2, SUB);
    wait_grant(5, "t5_regrant_seen");
    req_i = 2'b00;
    check_output("t5_regrant", last_gnt, 2'b01);
    wait_valid(20, "t5_valid_seen");

    // Done during ISSUE is ignored; a later done in WAIT completes
    set_stub(1'b0, 1, 16'd123, 16'd9);
    apply_stimulus(2'b01, 1'b0, 8'd40, 8'd2, DIV);
    wait_grant(5, "t6_grant_seen");
    req_i = 2'b00;
    manual_done = 1'b1;
    tick(1);
    manual_done = 1'b0;
    tick(3);
    manual_done = 1'b1;
    tick(1);
    manual_done = 1'b0;
    wait_valid(20, "t6_valid_seen");
    check_output("t6_latency", valid_cyc - gnt_cyc, 6);
    check_output("t6_res", res_o, 123);
    check_output("t6_rem", rem_o, 9);

    // Done on the final allowed WAIT cycle wins over timeout
    set_stub(1'b1, TO, 16'h1234, 16'h0042);
    apply_stimulus(2'b10, 1'b1, 8'd11, 8'd22, MUL);
    wait_grant(5, "t7_grant_seen");
    req_i = 2'b00;
    wait_valid(100, "t7_valid_seen");
    check_output("t7_latency", valid_cyc - start_cyc, 65);
    check_output("t7_err", err_o, 0);
    check_output("t7_res", res_o, 16'h1234);
    check_output("t7_rem", rem_o, 16'h0042);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/calc_scheduler.md
CALC_SCHEDULER -- requirements
Module: calc_scheduler

Interface
REQ-001 Parameter: width, default 8, operand width; results are 2*width.
REQ-002 Parameter: timeout_cycles, default 64, maximum WAIT cycles before abort; legal range 2..255.
REQ-003 Ports: clock_i  in  1  single clock; all state changes on its rising edge.
REQ-004 Ports: reset_i  in  1  reset, synchronous, active-high.
REQ-005 Ports: req_i  in  2  per-requester request level; index k is requester k.
REQ-006 Ports: a0_i, b0_i, a1_i, b1_i  in  width  operands of requester 0 and requester 1.
REQ-007 Ports: fct0_i, fct1_i  in  2  function code of each requester; passed through, not decoded.
REQ-008 Ports: gnt_o  out  2  one-hot one-cycle grant pulse.
REQ-009 Ports: calc_start_o  out  1  one-cycle start pulse to the calculator.
REQ-010 Ports: calc_a_o, calc_b_o  out  width  latched operands to the calculator.
REQ-011 Ports: calc_fct_o  out  2  latched function code to the calculator.
REQ-012 Ports: calc_res_i, calc_rem_i  in  2*width  calculator result and remainder.
REQ-013 Ports: calc_done_i  in  1  calculator completion.
REQ-014 Ports: res_o, rem_o  out  2*width  registered response data.
REQ-015 Ports: valid_o  out  2  one-hot one-cycle response strobe, index = served requester.
REQ-016 Ports: err_o  out  1  timeout flag, qualified by valid_o.
REQ-017 Ports: busy_o  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE with req_i != 0: select winner, pulse gnt_o[winner], latch winner's a/b/fct into calc_*_o, go ISSUE; with req_i == 0 remain IDLE.
REQ-020 Arbitration SHALL be round-robin: single request wins outright; on simultaneous requests the requester not served last wins; after reset requester 0 has priority.
REQ-021 ISSUE: calc_start_o=1 for exactly this cycle, clear timeout counter, go WAIT.
REQ-022 WAIT: calc_done_i=1 captures calc_res_i/calc_rem_i into res_o/rem_o, err_o=0, go RESP.
REQ-023 WAIT: counter increments each cycle without done; reaching timeout_cycles sets res_o=0, rem_o=0, err_o=1, go RESP.
REQ-024 calc_done_i SHALL be ignored outside WAIT; done and timeout in the same cycle resolves as done.
REQ-025 RESP: valid_o[winner]=1 for one cycle, last-served pointer := winner, go IDLE.
REQ-026 calc_a_o/calc_b_o/calc_fct_o SHALL stay stable from ISSUE through RESP; input changes after grant are ignored.
REQ-027 Requesters may deassert req_i after gnt_o; req_i held through RESP is a new request in the following IDLE.
REQ-028 Minimum transaction: grant cycle N, start N+1, done sampled N+2, valid N+3, next grant N+4.
REQ-029 res_o/rem_o/err_o SHALL hold their last value until the next RESP.

Reset
REQ-030 reset_i=1 at a clock edge: state IDLE, gnt_o=0, valid_o=0, calc_start_o=0, busy_o=0, err_o=0, all data outputs 0, counter 0, pointer favoring requester 0.
REQ-031 Reset mid-transaction SHALL abort it with no valid_o; a calc_done_i arriving after reset is ignored.

Structure
REQ-032 Shared package calc_pkg SHALL hold the FSM state enum and the 2-bit fct encoding constants (ADD, SUB, MUL, DIV).
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter2 (req[1:0], last-served in; one-hot grant out); the rest is inline.

Verification
REQ-034 Requester 0 only, a=12, b=5, fct=ADD, calculator stub done after 1 WAIT cycle with res=17 -> gnt_o=01, calc_start_o one pulse, valid_o=01, res_o=17, err_o=0, cycle timing per REQ-028.
REQ-035 Both requesting continuously after reset -> grants 01,10,01,10; each valid_o matches its grant.
REQ-036 Requester 1, a=200, b=7, fct=DIV, stub res=28 rem=4 after 5 cycles; a1_i changed after grant -> calc_a_o stays 200, valid_o=10, res_o=28, rem_o=4.
REQ-037 Stub never asserts done, timeout_cycles=64 -> valid_o pulses 64 WAIT cycles after start, err_o=1, res_o=0, rem_o=0.
REQ-038 reset_i pulsed during WAIT, then stub done -> no valid_o, all outputs 0, next simultaneous request grants requester 0.
REQ-039 calc_done_i high during ISSUE only -> ignored; transaction completes only on a later done in WAIT.
